// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, a valid/ack
// holding register, and one-cycle framing/overrun error pulses.
// Optional build macro UART_RX_MAJORITY_EN: every sample point takes a 2-of-3
// vote over rx_s at cnt == P-2, P-1, P instead of a single sample at P.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state, state_n;
   logic          rx_meta, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n, ferr_n, ovr_n;
   logic          samp;

   // Two-flop synchronizer; flops reset to the idle line level.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rx_h1, rx_h2;

   // History of rx_s; at cnt==P these hold the values from cnt==P-1 and P-2,
   // since every sample point lies at least two cycles into its state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_h1 <= 1'b1;
         rx_h2 <= 1'b1;
      end else begin
         rx_h1 <= rx_s;
         rx_h2 <= rx_h1;
      end
   end

   assign samp = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
   assign samp = rx_s;
`endif

   assign busy = (state != IDLE);

   // State, counters, shift register and output holding register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_idx_n;
         shreg       <= shreg_n;
         data_out    <= data_n;
         data_valid  <= valid_n;
         frame_err   <= ferr_n;
         overrun_err <= ovr_n;
      end
   end

   // Next-state, bit sampling, delivery and error pulses.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      data_n    = data_out;
      valid_n   = data_valid;
      ferr_n    = 1'b0;
      ovr_n     = 1'b0;

      if (data_ack && data_valid) begin
         valid_n = 1'b0;
      end

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) begin
               state_n = START;
            end
         end
         START: begin
            if (cnt == START_LAST) begin
               cnt_n = '0;
               if (!samp) begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               shreg_n = {samp, shreg[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (samp) begin
                  state_n = IDLE;
                  // A same-cycle ack frees the register, so the new byte replaces the old.
                  if (!data_valid || data_ack) begin
                     data_n  = shreg;
                     valid_n = 1'b1;
                  end else begin
                     ovr_n = 1'b1;
                  end
               end else begin
                  ferr_n  = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WAIT_HIGH: begin
            cnt_n = '0;
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares every cycle
// against a frame-level reference model (expected event cycle per frame).
module tb_uart_rx;

   localparam int CPB  = 32;
   localparam int HALF = CPB / 2;
   localparam int N    = HALF + 9 * CPB;
   // Line change driven after edge k reaches the stop-sample edge k+3+N.
   localparam int LAT  = 3 + N;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rx_in = 1'b1;
   logic       data_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_err, overrun_err, busy;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ack   (data_ack),
      .frame_err  (frame_err),
      .overrun_err(overrun_err),
      .busy       (busy)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned cyc;
      bit          ferr;
      logic [7:0]  b;
   } ev_t;

   ev_t         evq[$];
   int unsigned cyc = 0;
   logic [7:0]  m_data = '0;
   bit          m_valid = 0, m_ferr = 0, m_ovr = 0;

   // Each frame resolves at one precomputed cycle: good stop delivers or overruns, bad stop pulses frame_err.
   always @(posedge clk or negedge resetn) begin
      ev_t e;
      bit  have, good;
      if (!resetn) begin
         m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
         evq.delete();
      end else begin
         cyc++;
         m_ferr = 0; m_ovr = 0;
         have = 0; good = 0;
         if (evq.size() > 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            have = 1;
            good = !e.ferr;
            if (e.ferr) m_ferr = 1;
         end
         if (have && good) begin
            if (!m_valid || data_ack) begin
               m_data  = e.b;
               m_valid = 1;
            end else begin
               m_ovr = 1;
            end
         end else if (data_ack && m_valid) begin
            m_valid = 0;
         end
      end
   end

   // Per-cycle compare plus event counters used by directed checks.
   int unsigned ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, rise_cyc = 0;
   bit          prev_v = 0;
   always @(negedge clk) begin
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("data_out", 32'(data_out), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun_err", 32'(overrun_err), 32'(m_ovr));
      if (!resetn) check("busy_in_reset", 32'(busy), 32'd0);
      if (frame_err) ferr_cnt++;
      if (overrun_err) ovr_cnt++;
      if (busy) busy_cnt++;
      if (data_valid && !prev_v) rise_cyc = cyc;
      prev_v = data_valid;
   end

   // ---------------- consumer ----------------
   // mode 0: ack on request; mode 1: ack 1..10 cycles after valid; mode 2: random acks.
   int          ack_mode = 0, ack_delay = 0;
   int unsigned ack_req = 0, ack_done = 0;
   bit          ack_pend = 0;
   always begin
      @(posedge clk); #1;
      data_ack = 1'b0;
      if (ack_mode == 1) begin
         if (ack_pend) begin
            ack_delay--;
            if (ack_delay == 0) begin
               data_ack = 1'b1;
               ack_pend = 0;
            end
         end else if (data_valid) begin
            ack_pend  = 1;
            ack_delay = int'($urandom_range(1, 10));
         end
      end else if (ack_mode == 2) begin
         data_ack = ($urandom_range(0, 4) == 0);
      end else if (ack_req != ack_done) begin
         data_ack = 1'b1;
         ack_done++;
      end
   end

   // ---------------- stimulus ----------------
   int unsigned last_k = 0;

   task automatic send_frame(input logic [7:0] b, input int stop_low, input int abort_t,
                             input bit glitch, input int gap);
      int unsigned k;
      int          total, bitn;
      logic        v;
      ev_t         e;
      @(posedge clk); #1;
      k = cyc;
      last_k = k;
      if (abort_t < 0) begin
         e.cyc = k + LAT; e.ferr = (stop_low > 0); e.b = b;
         evq.push_back(e);
      end
      total = (stop_low > 0) ? (9 + stop_low) * CPB : 10 * CPB;
      for (int t = 0; t < total; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         if (t == abort_t) begin
            resetn = 1'b0; rx_in = 1'b1;
            repeat (3) @(posedge clk);
            #1 resetn = 1'b1;
            return;
         end
         bitn = t / CPB;
         if (bitn == 0) v = 1'b0;
         else if (bitn <= 8) v = b[bitn-1];
         else v = (stop_low > 0) ? 1'b0 : 1'b1;
         if (glitch && bitn >= 1 && bitn <= 8 && (t % CPB) == HALF) v = ~v;
         rx_in = v;
      end
      if (stop_low > 0 || gap > 0) begin
         @(posedge clk); #1 rx_in = 1'b1;
         repeat (gap * CPB) @(posedge clk);
      end
   endtask

   task automatic do_ack();
      ack_req++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int unsigned f0, o0, b0;
      bit          gl;
      resetn = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #1 resetn = 1'b1;
      repeat (2 * CPB) @(posedge clk);

      // 0xA5, latency window, then single ack
      send_frame(8'hA5, 0, -1, 0, 0);
      repeat (2) @(negedge clk);
      check("a5_data", 32'(data_out), 32'hA5);
      check("a5_valid", 32'(data_valid), 32'd1);
      check("a5_latency", 32'((rise_cyc - last_k) >= N && (rise_cyc - last_k) <= N + 3), 32'd1);
      do_ack();
      check("a5_ack_clears", 32'(data_valid), 32'd0);

      // Short low pulse on an idle line: busy pulses, nothing delivered
      b0 = busy_cnt; f0 = ferr_cnt;
      @(posedge clk); #1 rx_in = 1'b0;
      repeat (HALF - 6) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(data_valid), 32'd0);
      check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

      // 0x55 with stop held low two bit periods, then 0x3C
      f0 = ferr_cnt;
      send_frame(8'h55, 2, -1, 0, 1);
      @(negedge clk);
      check("ferr_once", 32'(ferr_cnt - f0), 32'd1);
      check("ferr_no_valid", 32'(data_valid), 32'd0);
      send_frame(8'h3C, 0, -1, 0, 0);
      repeat (2) @(negedge clk);
      check("after_ferr_data", 32'(data_out), 32'h3C);
      do_ack();

      // Overrun: 0x11 held, 0x22 dropped, then 0x33 after ack
      o0 = ovr_cnt;
      send_frame(8'h11, 0, -1, 0, 0);
      send_frame(8'h22, 0, -1, 0, 0);
      repeat (2) @(negedge clk);
      check("ovr_once", 32'(ovr_cnt - o0), 32'd1);
      check("ovr_keeps_data", 32'(data_out), 32'h11);
      do_ack();
      send_frame(8'h33, 0, -1, 0, 0);
      repeat (2) @(negedge clk);
      check("after_ovr_data", 32'(data_out), 32'h33);

      // Reset during data bit 4 (0x33 still held), then 0xC3
      send_frame(8'hC3, 0, 5 * CPB + 4, 0, 0);
      @(negedge clk);
      check("midrst_data", 32'(data_out), 32'h00);
      check("midrst_valid", 32'(data_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (2 * CPB) @(posedge clk);
`ifdef UART_RX_MAJORITY_EN
      gl = 1;
`else
      gl = 0;
`endif
      send_frame(8'hC3, 0, -1, gl, 0);
      repeat (2) @(negedge clk);
      check("c3_data", 32'(data_out), 32'hC3);
      do_ack();

      // Back-to-back 0x00, 0xFF with prompt consumer
      ack_mode = 1;
      o0 = ovr_cnt;
      send_frame(8'h00, 0, -1, 0, 0);
      send_frame(8'hFF, 0, -1, 0, 0);
      repeat (3) @(negedge clk);
      check("b2b_no_ovr", 32'(ovr_cnt - o0), 32'd0);
      check("b2b_last", 32'(data_out), 32'hFF);
      check("b2b_idle", 32'(busy), 32'd0);
      repeat (20) @(posedge clk);

      // Randomized frames with random acks and occasional bad stops
      ack_mode = 2;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] rb;
         bit         bad;
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         send_frame(rb, bad ? int'($urandom_range(1, 2)) : 0, -1, 0,
                    bad ? 1 : int'($urandom_range(0, 1)));
      end
      ack_mode = 0;
      repeat (2 * CPB) @(negedge clk);
      check("end_idle", 32'(busy), 32'd0);
      check("end_queue_empty", 32'(evq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
